// File: rtl/note_pkg.sv
`default_nettype none
// ============================================================================
// Module      : note_pkg
// Description : Shared definitions for the note interface. Holds the state
//               encodings of the receive-side period meter and of the
//               transmit-side note player so both ends use one definition.
// Revision    : 1.0  initial release
// ============================================================================
package note_pkg;

   // Period meter FSM. The encoding is visible on the meter's debug port.
   typedef enum logic [1:0] {
      ST_SYNC  = 2'b00,   // waiting for the first rise
      ST_HIGH  = 2'b01,   // measuring the high half-period
      ST_LOW   = 2'b10,   // measuring the low half-period
      ST_STALL = 2'b11    // a half-period saturated the counter
   } meter_state_t;

   // Note player FSM, used by the transmit side of the interface.
   typedef enum logic [1:0] {
      NP_IDLE    = 2'b00,
      NP_TONE_HI = 2'b01,
      NP_TONE_LO = 2'b10,
      NP_REST    = 2'b11
   } player_state_t;

   // Default duration counter width shared by both ends.
   localparam int unsigned C_NOTE_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/note_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : note_edge_det
// Description : One-cycle rise/fall detector for a signal that is already
//               synchronous to clk. The delayed copy resets to RESET_VAL so
//               the level present at reset release can be masked as an edge.
// Ports       : clk   in  clock
//               rst_n in  asynchronous active-low reset
//               note  in  synchronous input level
//               rise  out note is 1 now and was 0 on the previous cycle
//               fall  out note is 0 now and was 1 on the previous cycle
// Revision    : 1.0  initial release
// ============================================================================
module note_edge_det #(
   parameter bit RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic note,
   output logic rise,
   output logic fall
);

   logic r_note_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_note_q <= RESET_VAL;
      end else begin
         r_note_q <= note;
      end
   end

   assign rise =  note & ~r_note_q;
   assign fall = ~note &  r_note_q;

endmodule
`default_nettype wire

// File: rtl/note_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : note_period_meter
// Description : Measures the high and low half-periods of a synchronous
//               square wave. Each complete high+low pair is reported in clock
//               cycles with a one-cycle valid pulse; a half-period that
//               saturates the counter raises a timeout level.
// Ports       : clk          in  clock, rising edge
//               rst_n        in  asynchronous active-low reset
//               note         in  square wave, synchronous to clk
//               half_high    out high duration of the last complete pair
//               half_low     out low duration of the last complete pair
//               period_valid out one-cycle pulse, half_* just updated
//               timeout      out level, current half-period saturated
//               state        out FSM state for debug
// Revision    : 1.0  initial release
// ============================================================================
module note_period_meter
   import note_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             note,
   output logic [CNT_W-1:0] half_high,
   output logic [CNT_W-1:0] half_low,
   output logic             period_valid,
   output logic             timeout,
   output logic [1:0]       state
);

   localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
   localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // ------------------------------------------------------------------------
   // Edge detection; the delayed copy resets high so a note already high at
   // reset release is not taken as a rise.
   // ------------------------------------------------------------------------
   logic w_rise;
   logic w_fall;

   note_edge_det #(
      .RESET_VAL (1'b1)
   ) u_edge_det (
      .clk   (clk),
      .rst_n (rst_n),
      .note  (note),
      .rise  (w_rise),
      .fall  (w_fall)
   );

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   meter_state_t     r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_high_cap;
   logic [CNT_W-1:0] r_half_high;
   logic [CNT_W-1:0] r_half_low;
   logic             r_valid;
   logic             r_timeout;

   meter_state_t     w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_high_cap_nxt;
   logic [CNT_W-1:0] w_half_high_nxt;
   logic [CNT_W-1:0] w_half_low_nxt;
   logic             w_valid_nxt;
   logic             w_timeout_nxt;
   logic             w_cnt_sat;

   assign w_cnt_sat = (r_cnt == C_CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_SYNC;
         r_cnt       <= '0;
         r_high_cap  <= '0;
         r_half_high <= '0;
         r_half_low  <= '0;
         r_valid     <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_high_cap  <= w_high_cap_nxt;
         r_half_high <= w_half_high_nxt;
         r_half_low  <= w_half_low_nxt;
         r_valid     <= w_valid_nxt;
         r_timeout   <= w_timeout_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and datapath. The edge cycle counts as the first cycle of the
   // new level, hence the reload to 1. An edge wins over saturation, so a
   // half-period of exactly C_CNT_MAX cycles is still a valid measurement.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_high_cap_nxt  = r_high_cap;
      w_half_high_nxt = r_half_high;
      w_half_low_nxt  = r_half_low;
      w_valid_nxt     = 1'b0;
      w_timeout_nxt   = r_timeout;

      case (r_state)
         ST_SYNC: begin
            if (w_rise) begin
               w_state_nxt = ST_HIGH;
               w_cnt_nxt   = C_CNT_ONE;
            end
         end

         ST_HIGH: begin
            if (w_fall) begin
               w_high_cap_nxt = r_cnt;
               w_cnt_nxt      = C_CNT_ONE;
               w_state_nxt    = ST_LOW;
            end else if (w_cnt_sat) begin
               w_state_nxt   = ST_STALL;
               w_timeout_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + C_CNT_ONE;
            end
         end

         ST_LOW: begin
            if (w_rise) begin
               w_half_high_nxt = r_high_cap;
               w_half_low_nxt  = r_cnt;
               w_valid_nxt     = 1'b1;
               w_cnt_nxt       = C_CNT_ONE;
               w_state_nxt     = ST_HIGH;
            end else if (w_cnt_sat) begin
               w_state_nxt   = ST_STALL;
               w_timeout_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + C_CNT_ONE;
            end
         end

         ST_STALL: begin
            // The partial measurement is dropped; only a fresh rise restarts.
            if (w_rise) begin
               w_timeout_nxt = 1'b0;
               w_cnt_nxt     = C_CNT_ONE;
               w_state_nxt   = ST_HIGH;
            end
         end

         default: begin
            w_state_nxt = ST_SYNC;
         end
      endcase
   end

   assign half_high    = r_half_high;
   assign half_low     = r_half_low;
   assign period_valid = r_valid;
   assign timeout      = r_timeout;
   assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_note_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_note_period_meter
// Description : Self-checking bench for note_period_meter. Two instances
//               (16-bit and 4-bit counters) share one stimulus stream and are
//               compared every cycle against a run-length reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_note_period_meter;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic note  = 1'b0;

   logic [15:0] hh_a, hl_a;
   logic [3:0]  hh_b, hl_b;
   logic        pv_a, pv_b, to_a, to_b;
   logic [1:0]  st_a, st_b;

   always #5 clk = ~clk;

   note_period_meter #(.CNT_W(16)) u_dut_a (
      .clk          (clk),
      .rst_n        (rst_n),
      .note         (note),
      .half_high    (hh_a),
      .half_low     (hl_a),
      .period_valid (pv_a),
      .timeout      (to_a),
      .state        (st_a)
   );

   note_period_meter #(.CNT_W(4)) u_dut_b (
      .clk          (clk),
      .rst_n        (rst_n),
      .note         (note),
      .half_high    (hh_b),
      .half_low     (hl_b),
      .period_valid (pv_b),
      .timeout      (to_b),
      .state        (st_b)
   );

   int tests = 0;
   int fails = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model: tracks runs of equal samples. A run is "tracked" when
   // it began with a rise (high run) or followed a tracked high run (low run)
   // and has not exceeded the counter maximum.
   // ------------------------------------------------------------------------
   int m_max [2];
   bit m_lv  [2];
   int m_len [2];
   int m_trk [2];   // 0 none, 1 tracked high run, 2 tracked low run
   int m_hi  [2];
   bit m_to  [2];
   bit e_pv  [2];
   int e_hh  [2];
   int e_hl  [2];

   function automatic void model_reset(input int k);
      m_lv[k]  = 1'b1;
      m_len[k] = 0;
      m_trk[k] = 0;
      m_hi[k]  = 0;
      m_to[k]  = 1'b0;
      e_pv[k]  = 1'b0;
      e_hh[k]  = 0;
      e_hl[k]  = 0;
   endfunction

   function automatic void model_step(input int k, input bit n);
      e_pv[k] = 1'b0;
      if (n != m_lv[k]) begin
         if (n) begin
            if (m_trk[k] == 2) begin
               e_pv[k] = 1'b1;
               e_hh[k] = m_hi[k];
               e_hl[k] = m_len[k];
            end
            m_trk[k] = 1;
            m_to[k]  = 1'b0;
         end else if (m_trk[k] == 1) begin
            m_hi[k]  = m_len[k];
            m_trk[k] = 2;
         end
         m_len[k] = 1;
      end else begin
         m_len[k]++;
         if (m_trk[k] != 0 && m_len[k] > m_max[k]) begin
            m_trk[k] = 0;
            m_to[k]  = 1'b1;
         end
      end
      m_lv[k] = n;
   endfunction

   function automatic int exp_state(input int k);
      if (m_to[k])           return 3;
      else if (m_trk[k] == 1) return 1;
      else if (m_trk[k] == 2) return 2;
      else                    return 0;
   endfunction

   task automatic check_all(input string ph);
      check_val({ph, " a.valid"},   32'(pv_a), 32'(e_pv[0]));
      check_val({ph, " a.timeout"}, 32'(to_a), 32'(m_to[0]));
      check_val({ph, " a.state"},   32'(st_a), 32'(exp_state(0)));
      check_val({ph, " a.half_hi"}, 32'(hh_a), 32'(e_hh[0]));
      check_val({ph, " a.half_lo"}, 32'(hl_a), 32'(e_hl[0]));
      check_val({ph, " b.valid"},   32'(pv_b), 32'(e_pv[1]));
      check_val({ph, " b.timeout"}, 32'(to_b), 32'(m_to[1]));
      check_val({ph, " b.state"},   32'(st_b), 32'(exp_state(1)));
      check_val({ph, " b.half_hi"}, 32'(hh_b), 32'(e_hh[1]));
      check_val({ph, " b.half_lo"}, 32'(hl_b), 32'(e_hl[1]));
   endtask

   string phase = "init";

   // One clock: drive on the falling edge, check just after the rising edge.
   task automatic step(input bit n);
      @(negedge clk);
      note = n;
      @(posedge clk);
      #1;
      model_step(0, n);
      model_step(1, n);
      check_all(phase);
   endtask

   task automatic pair(input int h, input int l);
      repeat (h) step(1'b1);
      repeat (l) step(1'b0);
   endtask

   // Reset asserted between clock edges must clear outputs immediately.
   task automatic do_reset(input bit n);
      @(negedge clk);
      note = n;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset(0);
      model_reset(1);
      check_all({phase, " rst_async"});
      repeat (2) @(posedge clk);
      #1;
      check_all({phase, " rst_hold"});
      rst_n = 1'b1;
   endtask

   initial begin
      m_max[0] = 65535;
      m_max[1] = 15;
      model_reset(0);
      model_reset(1);

      phase = "reset";
      do_reset(1'b0);

      phase = "idle_low";
      repeat (100) step(1'b0);

      phase = "h5l3";
      repeat (6) pair(5, 3);

      phase = "h1l1";
      repeat (10) pair(1, 1);

      phase = "stall";
      repeat (20) step(1'b1);
      repeat (3) step(1'b0);
      repeat (3) pair(4, 2);

      phase = "edge_at_max";
      pair(15, 15);
      pair(3, 2);

      phase = "high_at_release";
      do_reset(1'b1);
      repeat (4) step(1'b1);
      repeat (3) pair(6, 2);

      phase = "mid_low_reset";
      repeat (2) pair(5, 3);
      repeat (5) step(1'b1);
      repeat (2) step(1'b0);
      do_reset(1'b0);
      repeat (3) step(1'b0);
      repeat (2) pair(5, 3);

      phase = "random";
      for (int i = 0; i < 40; i++) begin
         int h;
         int l;
         h = int'($urandom_range(1, 18));
         l = int'($urandom_range(1, 18));
         pair(h, l);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/note_period_meter.md
# note_period_meter

Measures the high and low half-periods of a synchronous square-wave `note` signal, such as the output of the note player. After each complete high+low pair it reports both durations in clock cycles with a one-cycle valid pulse. It flags a stalled or absent tone with a timeout level. It sits on the receive side of the note interface and is used for loopback checking and tone decoding.

## Interface
- `CNT_W`, default 16: width of the duration counter and of the `half_high`/`half_low` outputs.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `note`  in  1  square wave, already synchronous to `clk`.
- `half_high`  out  CNT_W  high duration, in cycles, of the last complete pair.
- `half_low`  out  CNT_W  low duration, in cycles, of the last complete pair.
- `period_valid`  out  1  one-cycle pulse; the `half_*` outputs just updated.
- `timeout`  out  1  level; the current half-period saturated the counter.
- `state`  out  2  FSM state, exported for debug and test.

## Operation
- Edge detect uses a 1-bit register `note_q`:
  - rise = `note & ~note_q`
  - fall = `~note & note_q`
- `note_q` resets to 1, so a high level present at reset release is not a rise.
- Duration counter `cnt` is CNT_W bits, unsigned, and saturates at 2^CNT_W-1. It never wraps.
- A duration counts the cycles on which `note` was sampled at that level, including the edge cycle.
- FSM states:
  - SYNC=00, reset state:
    - Waits for a rise, then goes to HIGH with `cnt`<=1.
    - Falls are ignored.
    - No timeout in SYNC.
  - HIGH=01:
    - While `note`=1, `cnt`++.
    - On a fall: `high_cap`<=`cnt`, `cnt`<=1, go to LOW.
    - If `cnt` reaches max while still high: go to STALL, `timeout`<=1.
  - LOW=10:
    - While `note`=0, `cnt`++.
    - On a rise: `half_high`<=`high_cap`, `half_low`<=`cnt`, `period_valid`<=1, `cnt`<=1, go to HIGH.
    - If `cnt` reaches max while still low: go to STALL, `timeout`<=1.
  - STALL=11:
    - Holds `timeout`=1.
    - On a rise: `timeout`<=0, `cnt`<=1, go to HIGH.
    - Falls are ignored.
    - The partial measurement is discarded and no valid pulse is produced.
- A pair is reported only if it starts on a rise seen in HIGH-entry, so the first valid pulse always needs one full high phase plus one full low phase.
- `half_high` and `half_low` hold their last values until the next valid pair. They are not cleared by a timeout.

## Timing
- Reset values:
  - `state`=SYNC
  - `half_high`=0, `half_low`=0
  - `period_valid`=0, `timeout`=0
  - `cnt`=0, `high_cap`=0, `note_q`=1
- Reset is asynchronous. Asserting it mid-measurement clears everything immediately. No valid pulse is emitted for the partial pair.
- Latency: `period_valid` and the updated `half_*` values appear on the clock edge that samples the rise ending the low phase. They are visible one cycle after `note` goes high.
- `period_valid` is high for exactly one cycle per pair. Pairs are back-to-back: steady H/L input gives one pulse every H+L cycles.
- Minimum legal half-period is 1 cycle. With H=1, L=1 every rise and fall is captured.
- Saturation: with `cnt`=max and the level unchanged, the transition to STALL and `timeout`=1 occur on that edge.
- An edge on the same cycle `cnt` reaches max takes priority: the measurement is captured with value max and there is no timeout.

## Structure
- Shared package `note_pkg` holds:
  - the 2-bit state encodings SYNC/HIGH/LOW/STALL
  - the note-player state encodings, so both ends share one definition
- Sub-module `note_edge_det` contains the `note_q` register plus the rise/fall outputs. Its reset value is a parameter, set to 1 here.
- State, counter and capture registers all use the async active-low reset flop style.

## Test plan
- Reset, then `note`=0 for 100 cycles -> `state`=00, `period_valid` never asserts, `timeout`=0.
- Drive H=5, L=3 repeatedly -> first pulse one cycle after the 2nd rise, then every 8 cycles, with `half_high`=5, `half_low`=3.
- H=1, L=1 -> `period_valid` every 2 cycles after the first pair, values 1/1.
- CNT_W=4, rise then hold high for 20 cycles -> `timeout`=1 and `state`=11 once `cnt`=15. Then fall, then rise -> `timeout`=0, `state`=01, and the next valid pulse reports only the next full pair. `half_*` keep their old values meanwhile.
- `note`=1 at reset release, fall after 4 cycles, then H=6, L=2 -> no capture of the partial high; first pulse reports 6/2.
- Assert `rst_n`=0 mid-LOW after one valid pair (values 5/3) -> all outputs go to 0 immediately and `state`=00. After release, no pulse until a new full pair.
